// File: rtl/raster_tracker_if.sv
// raster_tracker_if: pixel stream bundle for raster_tracker
//   upstream   : valid_i, data_i in; ready_o out
//   downstream : valid_o, data_o, col_o, row_o, sof_o, eol_o, eof_o, border_o, frame_cnt_o out; ready_i in
//   slave modport is the tracker's view, master modport is the driving/observing side
interface raster_tracker_if #(
    parameter int DATA_WIDTH_P = 8,
    parameter int CNT_WIDTH_P  = 16
);
    logic                    valid_i;
    logic                    ready_o;
    logic [DATA_WIDTH_P-1:0] data_i;
    logic                    valid_o;
    logic                    ready_i;
    logic [DATA_WIDTH_P-1:0] data_o;
    logic [CNT_WIDTH_P-1:0]  col_o;
    logic [CNT_WIDTH_P-1:0]  row_o;
    logic                    sof_o;
    logic                    eol_o;
    logic                    eof_o;
    logic                    border_o;
    logic [CNT_WIDTH_P-1:0]  frame_cnt_o;
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, col_o, row_o, sof_o, eol_o, eof_o, border_o, frame_cnt_o
    );
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, col_o, row_o, sof_o, eol_o, eof_o, border_o, frame_cnt_o
    );
endinterface

// File: rtl/raster_tracker.sv
// raster_tracker: tags a raster pixel stream with column/row, frame flags and a frame count
//   clk_i     : clock, rising edge
//   rstn_i    : asynchronous active-low reset
//   restart_i : forces the next accepted pixel to (0,0)
//   bus       : raster_tracker_if.slave, valid/ready stream in, registered tagged stream out
module raster_tracker #(
    parameter int DATA_WIDTH_P = 8,
    parameter int FRAME_W_P    = 640,
    parameter int FRAME_H_P    = 480,
    parameter int CNT_WIDTH_P  = 16
) (
    input logic             clk_i,
    input logic             rstn_i,
    input logic             restart_i,
    raster_tracker_if.slave bus
);
    localparam logic [CNT_WIDTH_P-1:0] LAST_COL = CNT_WIDTH_P'(FRAME_W_P - 1);
    localparam logic [CNT_WIDTH_P-1:0] LAST_ROW = CNT_WIDTH_P'(FRAME_H_P - 1);
    localparam logic [CNT_WIDTH_P-1:0] ONE      = CNT_WIDTH_P'(1);

    logic [CNT_WIDTH_P-1:0]  col_q, col_d, row_q, row_d, frame_q, frame_d;
    logic [CNT_WIDTH_P-1:0]  col_out_q, col_out_d, row_out_q, row_out_d;
    logic [CNT_WIDTH_P-1:0]  tag_col, tag_row;
    logic [DATA_WIDTH_P-1:0] data_q, data_d;
    logic                    valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, border_q, border_d;
    logic                    accept, last_col, last_row;

    assign bus.ready_o     = !valid_q || bus.ready_i;
    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.col_o       = col_out_q;
    assign bus.row_o       = row_out_q;
    assign bus.sof_o       = sof_q;
    assign bus.eol_o       = eol_q;
    assign bus.eof_o       = eof_q;
    assign bus.border_o    = border_q;
    assign bus.frame_cnt_o = frame_q;

    // restart folds into the tag: with no accept the position simply becomes (0,0),
    // with an accept the pixel is tagged (0,0) and the position advances from there
    always_comb begin
        accept    = bus.valid_i && bus.ready_o;
        tag_col   = restart_i ? '0 : col_q;
        tag_row   = restart_i ? '0 : row_q;
        last_col  = tag_col == LAST_COL;
        last_row  = tag_row == LAST_ROW;
        col_d     = accept ? (last_col ? '0 : tag_col + ONE) : tag_col;
        row_d     = (accept && last_col) ? (last_row ? '0 : tag_row + ONE) : tag_row;
        frame_d   = frame_q + ((accept && last_col && last_row) ? ONE : '0);
        valid_d   = accept || (valid_q && !bus.ready_i);
        data_d    = accept ? bus.data_i : data_q;
        col_out_d = accept ? tag_col : col_out_q;
        row_out_d = accept ? tag_row : row_out_q;
        sof_d     = accept ? (tag_col == '0 && tag_row == '0) : sof_q;
        eol_d     = accept ? last_col : eol_q;
        eof_d     = accept ? (last_col && last_row) : eof_q;
        border_d  = accept ? (tag_col == '0 || last_col || tag_row == '0 || last_row) : border_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q     <= '0;
            row_q     <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            border_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            col_out_q <= col_out_d;
            row_out_q <= row_out_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            border_q  <= border_d;
        end
    end
endmodule

// File: tb/tb_raster_tracker.sv
// tb_raster_tracker: scoreboard bench for raster_tracker on a 4x3 frame
module tb_raster_tracker;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        logic          sof;
        logic          eol;
        logic          eof;
        logic          border;
        logic [CW-1:0] frame;
    } pix_t;

    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    logic restart_i = 1'b0;
    int   total = 0;
    int   bad = 0;
    pix_t sb[$];
    pix_t mon_act, mon_exp;
    int   mcol = 0, mrow = 0, mframe = 0, tc, tr;

    raster_tracker_if #(.DATA_WIDTH_P(DW), .CNT_WIDTH_P(CW)) bus ();

    raster_tracker #(
        .DATA_WIDTH_P(DW),
        .FRAME_W_P(W),
        .FRAME_H_P(H),
        .CNT_WIDTH_P(CW)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .restart_i(restart_i),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: push the expected tagged pixel on every accepted beat, pop on every emitted beat.
    always @(negedge clk) begin
        if (!rstn_i) begin
            sb.delete();
            mcol = 0;
            mrow = 0;
            mframe = 0;
        end else begin
            if (bus.valid_o && bus.ready_i) begin
                mon_act.data   = bus.data_o;
                mon_act.col    = bus.col_o;
                mon_act.row    = bus.row_o;
                mon_act.sof    = bus.sof_o;
                mon_act.eol    = bus.eol_o;
                mon_act.eof    = bus.eof_o;
                mon_act.border = bus.border_o;
                mon_act.frame  = bus.frame_cnt_o;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_pixel got=%h expected none", mon_act);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL sb_pixel got=%h expected=%h", mon_act, mon_exp);
                    end
                end
            end
            if (bus.valid_i && bus.ready_o) begin
                tc = restart_i ? 0 : mcol;
                tr = restart_i ? 0 : mrow;
                mon_exp.data   = bus.data_i;
                mon_exp.col    = CW'(tc);
                mon_exp.row    = CW'(tr);
                mon_exp.sof    = (tc == 0) && (tr == 0);
                mon_exp.eol    = tc == W - 1;
                mon_exp.eof    = (tc == W - 1) && (tr == H - 1);
                mon_exp.border = !(tc > 0 && tc < W - 1 && tr > 0 && tr < H - 1);
                if (tc == W - 1) begin
                    mcol = 0;
                    if (tr == H - 1) begin
                        mrow = 0;
                        mframe++;
                    end else mrow = tr + 1;
                end else begin
                    mcol = tc + 1;
                    mrow = tr;
                end
                mon_exp.frame = CW'(mframe);
                sb.push_back(mon_exp);
            end else if (restart_i) begin
                mcol = 0;
                mrow = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold ready/valid got=%b%b expected=10", bus.ready_o, bus.valid_o);
        end
        rstn_i = 1'b1;
        tick();
        bus.valid_i = 1'b1;
        bus.data_i = 8'hA5;
        tick();
        bus.data_i = 8'h5A;
        tick();
        bus.valid_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        total++;
        if ({bus.valid_o, bus.data_o} !== '0) begin
            bad++;
            $display("FAIL async_reset valid/data got=%b/%h expected=0/00", bus.valid_o, bus.data_o);
        end
        total++;
        if ({bus.col_o, bus.row_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.border_o, bus.frame_cnt_o} !== '0) begin
            bad++;
            $display("FAIL async_reset tags got col=%0d row=%0d flags=%b%b%b%b frame=%0d expected all 0",
                     bus.col_o, bus.row_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.border_o, bus.frame_cnt_o);
        end
        tick();
        rstn_i = 1'b1;
        tick();
        total++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready/valid got=%b%b expected=10", bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_stream();
        logic [DW+2*CW+3:0] got_v, exp_v;
        for (int k = 0; k < 12; k++) begin
            bus.valid_i = 1'b1;
            bus.data_i = DW'(k);
            tick();
            exp_v = {DW'(k), CW'(k % 4), CW'(k / 4), k == 0, k % 4 == 3, k == 11, !(k == 5 || k == 6)};
            got_v = {bus.data_o, bus.col_o, bus.row_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.border_o};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL stream_pixel_%0d got=%h expected=%h", k, got_v, exp_v);
            end
        end
        total++;
        if (bus.frame_cnt_o !== CW'(1)) begin
            bad++;
            $display("FAIL stream_frame_cnt got=%0d expected=1", bus.frame_cnt_o);
        end
        bus.valid_i = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW+3*CW+4:0] snap, now_v;
        for (int k = 0; k < 8; k++) begin
            bus.valid_i = 1'b1;
            bus.data_i = DW'(100 + k);
            if (k == 4) begin
                bus.ready_i = 1'b0;
                #1;
                snap = {bus.valid_o, bus.data_o, bus.col_o, bus.row_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.border_o, bus.frame_cnt_o};
                repeat (3) begin
                    tick();
                    now_v = {bus.valid_o, bus.data_o, bus.col_o, bus.row_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.border_o, bus.frame_cnt_o};
                    total++;
                    if (bus.ready_o !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_ready got=%b expected=0", bus.ready_o);
                    end
                    total++;
                    if (now_v !== snap) begin
                        bad++;
                        $display("FAIL stall_stable got=%h expected=%h", now_v, snap);
                    end
                end
                bus.ready_i = 1'b1;
            end
            tick();
        end
        bus.valid_i = 1'b0;
        tick();
    endtask

    task automatic test_bubbles();
        int acc = 0;
        int cyc = 0;
        while (acc < 10 && cyc < 200) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.data_i = DW'(200 + acc);
            tick();
            cyc++;
            if (bus.valid_i) begin
                acc++;
                if (acc == 4) begin
                    total++;
                    if (bus.frame_cnt_o !== CW'(2) || bus.eof_o !== 1'b1) begin
                        bad++;
                        $display("FAIL bubble_frame_end frame=%0d eof=%b expected frame=2 eof=1", bus.frame_cnt_o, bus.eof_o);
                    end
                end
                if (acc == 5) begin
                    total++;
                    if ({bus.sof_o, bus.col_o, bus.row_o} !== {1'b1, CW'(0), CW'(0)}) begin
                        bad++;
                        $display("FAIL bubble_second_sof sof=%b col=%0d row=%0d expected sof=1 (0,0)", bus.sof_o, bus.col_o, bus.row_o);
                    end
                end
            end else begin
                total++;
                if (bus.valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL bubble_valid got=%b expected=0", bus.valid_o);
                end
            end
        end
        if (acc < 10) begin
            total++;
            bad++;
            $display("FAIL bubble_timeout accepted=%0d expected=10", acc);
        end
        bus.valid_i = 1'b0;
        tick();
    endtask

    task automatic test_restart();
        logic [CW-1:0] fc;
        for (int k = 0; k < 5; k++) begin
            bus.valid_i = 1'b1;
            bus.data_i = DW'(30 + k);
            tick();
        end
        fc = bus.frame_cnt_o;
        bus.valid_i = 1'b0;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i = 8'd50;
        tick();
        total++;
        if ({bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o} !== {8'd50, 1'b1, CW'(0), CW'(0), fc}) begin
            bad++;
            $display("FAIL restart_idle data=%0d sof=%b col=%0d row=%0d frame=%0d expected 50 1 (0,0) %0d",
                     bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o, fc);
        end
        bus.data_i = 8'd51;
        tick();
        bus.data_i = 8'd52;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        total++;
        if ({bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o} !== {8'd52, 1'b1, CW'(0), CW'(0), fc}) begin
            bad++;
            $display("FAIL restart_accept data=%0d sof=%b col=%0d row=%0d frame=%0d expected 52 1 (0,0) %0d",
                     bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o, fc);
        end
        bus.data_i = 8'd53;
        tick();
        total++;
        if ({bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o} !== {8'd53, 1'b0, CW'(1), CW'(0), fc}) begin
            bad++;
            $display("FAIL restart_follow data=%0d sof=%b col=%0d row=%0d frame=%0d expected 53 0 (1,0) %0d",
                     bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o, fc);
        end
        bus.valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_hold();
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i = 8'd77;
        tick();
        bus.valid_i = 1'b0;
        tick();
        total++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== 8'd77) begin
            bad++;
            $display("FAIL hold_before_reset valid=%b data=%0d expected 1 77", bus.valid_o, bus.data_o);
        end
        #2 rstn_i = 1'b0;
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_reset_drop valid=%b ready=%b expected 0 1", bus.valid_o, bus.ready_o);
        end
        tick();
        rstn_i = 1'b1;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i = 8'd88;
        tick();
        total++;
        if ({bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o} !== {8'd88, 1'b1, CW'(0), CW'(0), CW'(0)}) begin
            bad++;
            $display("FAIL post_reset_pixel data=%0d sof=%b col=%0d row=%0d frame=%0d expected 88 1 (0,0) 0",
                     bus.data_o, bus.sof_o, bus.col_o, bus.row_o, bus.frame_cnt_o);
        end
        bus.valid_i = 1'b0;
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain pending=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i = '0;
        bus.ready_i = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_restart();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raster_tracker.md
# raster_tracker

Pixel-stream position tracker placed directly upstream of the Sobel line buffers and window logic. It accepts a raster-ordered pixel stream over a valid/ready handshake and re-emits each pixel one cycle later. Each output pixel carries its column/row coordinates, start-of-frame, end-of-line and end-of-frame flags, and a border flag. The position state is a pair of rollover up-counters (column, row) plus a frame counter, all advanced only on accepted input beats.

## Interface
Parameters:
- DATA_WIDTH_P, 8, pixel data width
- FRAME_W_P, 640, pixels per line (>= 2)
- FRAME_H_P, 480, lines per frame (>= 2)
- CNT_WIDTH_P, 16, width of column/row/frame counters; must hold FRAME_W_P-1 and FRAME_H_P-1

Ports:
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  reset: asynchronous, active-low; asserts immediately, releases synchronously to clk_i
- restart_i  in  1  synchronous frame restart; forces next accepted pixel to (0,0)
- valid_i  in  1  input pixel valid
- ready_o  out  1  input ready
- data_i  in  DATA_WIDTH_P  input pixel
- valid_o  out  1  output pixel valid
- ready_i  in  1  downstream ready
- data_o  out  DATA_WIDTH_P  registered pixel
- col_o  out  CNT_WIDTH_P  column of data_o
- row_o  out  CNT_WIDTH_P  row of data_o
- sof_o  out  1  data_o is (0,0)
- eol_o  out  1  col_o == FRAME_W_P-1
- eof_o  out  1  eol_o and row_o == FRAME_H_P-1
- border_o  out  1  col_o in {0, FRAME_W_P-1} or row_o in {0, FRAME_H_P-1}
- frame_cnt_o  out  CNT_WIDTH_P  number of completed frames, wraps mod 2^CNT_WIDTH_P

## Operation
- Accept = valid_i && ready_o. Emit = valid_o && ready_i.
- ready_o = !valid_o || ready_i (combinational; single output register, full throughput, no skid buffer).
- On accept: data_i, current (col,row), and the derived flags load into the output register; valid_o sets.
- On emit without accept: valid_o clears. While valid_o && !ready_i, all outputs hold stable.
- Internal position (col_q,row_q) is the coordinate of the next pixel to be accepted.
  - Advance on accept: col_q+1; at col_q == FRAME_W_P-1, col_q -> 0 and row_q+1.
  - At the last pixel (FRAME_W_P-1, FRAME_H_P-1), both wrap to 0 and frame_cnt_o increments.
- restart_i, no accept in the same cycle: col_q, row_q -> 0. frame_cnt_o is unchanged. The output register is unaffected.
- restart_i with accept in the same cycle: the accepted pixel is tagged (0,0) with sof_o = 1, and the position becomes (1,0).
- Flags are computed from the tagged coordinates at load time. They are registered, never derived from live counters.
- Counter values never exceed FRAME_W_P-1 / FRAME_H_P-1. frame_cnt_o rolls 2^CNT_WIDTH_P-1 -> 0.

## Timing
- Reset values: valid_o = 0, data_o = 0, col_o = 0, row_o = 0, all flags = 0, frame_cnt_o = 0; internal position (0,0).
- ready_o = 1 during and after reset while valid_o = 0.
- Latency: pixel accepted in cycle N appears on outputs in cycle N+1.
- Throughput: sustained one pixel/cycle when ready_i is held high.
- Reset mid-frame: position returns to (0,0) and any held output pixel is dropped (valid_o = 0). The first pixel accepted after release is tagged sof.
- frame_cnt_o updates in the cycle after the eof pixel is accepted, i.e. with the same edge that loads the eof pixel into the output register.

## Test plan
Use FRAME_W_P = 4, FRAME_H_P = 3.

1. Reset check: assert rstn_i low asynchronously mid-cycle -> all outputs 0 immediately, ready_o = 1 after release.
2. Stream 12 pixels (data 0..11) with valid_i = 1, ready_i = 1 -> outputs follow one cycle behind the inputs, with:
   - col/row sequence (0,0)..(3,2)
   - sof on data 0; eol on 3, 7, 11; eof on 11
   - border set on all pixels except data 5 and 6
   - frame_cnt_o = 1 after pixel 11
3. Downstream backpressure: hold ready_i = 0 for 3 cycles mid-stream -> ready_o = 0, outputs stable, no pixel lost or duplicated, coordinates continue correctly after release.
4. Input bubbles: random valid_i gaps -> coordinates advance only on accepted beats. A second frame repeats (0,0) sof with frame_cnt_o = 2 at its end.
5. restart_i after 5 pixels, with no input that cycle -> next pixel tagged (0,0) with sof. restart_i coincident with accept -> that pixel tagged (0,0), the following one (1,0). frame_cnt_o unchanged in both cases.
6. Reset asserted while valid_o = 1 and ready_i = 0 -> valid_o drops to 0 immediately. The first post-reset pixel is tagged (0,0) with sof.
